// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU constants and elaboration helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int FPU_MANT_W = 24;

    // A one-requester or two-requester arbiter still needs a 1-bit ID field.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/padder24.sv
`default_nettype none
// ============================================================================
// Module      : padder24
// Description : 24-bit Kogge-Stone parallel-prefix adder with carry-in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module padder24
    import fpu_pkg::*;
(
    input  logic [FPU_MANT_W-1:0] a,
    input  logic [FPU_MANT_W-1:0] b,
    input  logic                  cin,
    output logic [FPU_MANT_W-1:0] sum,
    output logic                  cout
);

    localparam int c_levels = 5;

    logic [c_levels:0][FPU_MANT_W-1:0] w_g;
    logic [c_levels:0][FPU_MANT_W-1:0] w_p;
    logic [FPU_MANT_W:0]               w_c;

    assign w_g[0] = a & b;
    assign w_p[0] = a ^ b;

    for (genvar l = 0; l < c_levels; l++) begin : g_level
        for (genvar i = 0; i < FPU_MANT_W; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_merge
                assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
                assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
            end else begin : g_pass
                assign w_g[l+1][i] = w_g[l][i];
                assign w_p[l+1][i] = w_p[l][i];
            end
        end
    end

    // Final prefix spans bit 0..i, so the carry-in folds in with one AND-OR.
    assign w_c  = {w_g[c_levels] | (w_p[c_levels] & {FPU_MANT_W{cin}}), cin};
    assign sum  = w_p[0] ^ w_c[FPU_MANT_W-1:0];
    assign cout = w_c[FPU_MANT_W];

endmodule
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin selector, search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic w_found;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin : g_search
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_adder_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_adder_arb
// Description : Round-robin sharing of one padder24 with a 1-entry result reg.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_adder_arb
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*W-1:0]          req_a,
    input  logic [NREQ*W-1:0]          req_b,
    input  logic [NREQ-1:0]            req_cin,
    input  logic [NREQ-1:0]            req_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_sum,
    output logic                       rsp_cout,
    output logic [clog2_min1(NREQ)-1:0] rsp_id
);

    localparam int IDW = clog2_min1(NREQ);

    if (W != FPU_MANT_W) begin : g_bad_width
        $error("fpu_addsub_adder_arb: W must equal FPU_MANT_W");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fpu_addsub_adder_arb: NREQ must be 2..8");
    end

    logic            r_rsp_valid;
    logic [W-1:0]    r_rsp_sum;
    logic            r_rsp_cout;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  r_rr_ptr;

    logic            w_slot_free;
    logic [NREQ-1:0] w_req_masked;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_any_gnt;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_cin;
    logic [W-1:0]    w_sum;
    logic            w_cout;

    // Masking before the selector keeps req_ready independent of operands.
    assign w_slot_free  = !r_rsp_valid || rsp_ready;
    assign w_req_masked = (rst || !w_slot_free) ? '0 : req_valid;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req    (w_req_masked),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign req_ready = w_gnt;
    assign w_any_gnt = |w_gnt;

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a   = req_a[i*W +: W];
                w_b   = req_sub[i] ? ~req_b[i*W +: W] : req_b[i*W +: W];
                w_cin = req_sub[i] ? 1'b1 : req_cin[i];
            end
        end
    end

    padder24 u_padder24 (
        .a    (w_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_any_gnt) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_id    <= w_gnt_id;
            r_rr_ptr    <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_adder_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub_adder_arb
// Description : Directed self-checking bench for fpu_addsub_adder_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_adder_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_sum;
    logic        rsp_cout;
    logic [1:0]  rsp_id;

    int n_cmp = 0;
    int n_err = 0;

    fpu_addsub_adder_arb #(
        .NREQ (4),
        .W    (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b,
                           input logic cin, input logic sub);
        req_a[i*24 +: 24] = a;
        req_b[i*24 +: 24] = b;
        req_cin[i]        = cin;
        req_sub[i]        = sub;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [23:0] s,
                           input logic c, input logic [1:0] id);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_sum"},   32'(rsp_sum),   32'(s));
        chk({tag, "_cout"},  32'(rsp_cout),  32'(c));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
    endtask

    initial begin
        int e;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset must not be accepted
        req_valid = 4'hF;
        #2 chk("ready_in_rst", 32'(req_ready), 32'h0);
        cyc();
        chk_rsp("reset", 1'b0, 24'h0, 1'b0, 2'd0);
        rst       = 1'b0;
        req_valid = '0;

        // 1 + 2 + cin on requester 0
        set_req(0, 24'h000001, 24'h000002, 1'b1, 1'b0);
        req_valid = 4'b0001;
        #2 chk("add_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        chk_rsp("add", 1'b1, 24'h000004, 1'b0, 2'd0);

        // 5 - 7 on requester 2 (cin=0 must be ignored)
        set_req(2, 24'h000005, 24'h000007, 1'b0, 1'b1);
        req_valid = 4'b0100;
        #2 chk("sub_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        chk_rsp("sub_borrow", 1'b1, 24'hFFFFFE, 1'b0, 2'd2);

        // 7 - 5 on requester 2
        set_req(2, 24'h000007, 24'h000005, 1'b0, 1'b1);
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        chk_rsp("sub_noborrow", 1'b1, 24'h000002, 1'b1, 2'd2);

        // Overflow on requester 1
        set_req(1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        chk_rsp("ovf", 1'b1, 24'h000000, 1'b1, 2'd1);

        // Drain with no request: valid drops, data holds
        cyc();
        chk_rsp("drain", 1'b0, 24'h000000, 1'b1, 2'd1);

        // All four valid; pointer is now 2 so order is 2,3,0,1,...
        for (int i = 0; i < 4; i++) set_req(i, 24'(i * 16), 24'h000001, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            e = (2 + k) % 4;
            #2 chk("rr_ready", 32'(req_ready), 32'(1 << e));
            cyc();
            chk_rsp("rr", 1'b1, 24'(e * 16 + 1), 1'b0, 2'(e));
        end

        // Backpressure: everything holds, no grants
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2 chk("bp_ready", 32'(req_ready), 32'h0);
            cyc();
            chk_rsp("bp_hold", 1'b1, 24'h000011, 1'b0, 2'd1);
        end

        // Release: drain and grant to requester 2 in the same cycle
        rsp_ready = 1'b1;
        #2 chk("rel_ready", 32'(req_ready), 32'h4);
        cyc();
        chk_rsp("rel", 1'b1, 24'h000021, 1'b0, 2'd2);

        // Grant requester 1 so the pointer lands on 2 with a held result
        req_valid = 4'b0010;
        cyc();
        chk_rsp("pre_rst", 1'b1, 24'h000011, 1'b0, 2'd1);

        req_valid = 4'hF;
        rst       = 1'b1;
        #2 chk("rst_ready", 32'(req_ready), 32'h0);
        cyc();
        chk_rsp("mid_rst", 1'b0, 24'h0, 1'b0, 2'd0);

        // Pointer restarts at 0: requester 1 wins over 2
        rst       = 1'b0;
        req_valid = 4'b0110;
        #2 chk("post_rst_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        chk_rsp("post_rst", 1'b1, 24'h000011, 1'b0, 2'd1);

        cyc();
        chk("final_valid", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_adder_arb.md
# fpu_addsub_adder_arb

Round-robin arbiter and output stage that shares one 24-bit parallel-prefix mantissa adder (`padder24`) between up to `NREQ` requesters in the FPU add/sub path. Each requester presents an add or subtract with a valid/ready handshake. The arbiter grants at most one request per cycle and drives the shared adder. It captures the sum, carry-out and requester ID in a single-entry output register drained through a second valid/ready handshake. Typical requesters: add/sub mantissa alignment path, rounding increment path, exponent-adjust path.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 24: operand width; fixed to 24 to match `padder24`. Any other value is an elaboration error.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  grant/accept, one-hot or zero.
- `req_a`  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B, packed the same way.
- `req_cin`  in  NREQ  carry-in; ignored when `req_sub[i]`=1.
- `req_sub`  in  NREQ  1 = compute A - B.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  W  registered sum.
- `rsp_cout`  out  1  registered carry-out (for subtract: 1 = no borrow, A >= B).
- `rsp_id`  out  IDW  index of the granted requester, IDW = $clog2(NREQ).

## Operation
- Slot is free when `!rsp_valid || rsp_ready`. No grant is made when the slot is not free; in that case `req_ready` = 0.
- Arbitration is round-robin. Pointer `rr_ptr` has IDW bits and resets to 0.
  - Search order: `rr_ptr`, `rr_ptr`+1, … mod NREQ.
  - The first requester with `req_valid` set is granted.
- Grant to requester g: `req_ready[g]` = 1 in the same cycle. `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`.
  - `req_ready` never depends on the operand buses.
- Adder inputs for the granted requester:
  - A = `req_a[g]`.
  - B = `req_sub[g]` ? ~`req_b[g]` : `req_b[g]`.
  - Cin = `req_sub[g]` ? 1 : `req_cin[g]`.
- On a grant edge:
  - Load `rsp_sum`, `rsp_cout` and `rsp_id` = g.
  - Set `rsp_valid` = 1.
  - Set `rr_ptr` = (g+1) mod NREQ.
- Drain without grant (`rsp_valid && rsp_ready`, no `req_valid` set): `rsp_valid` = 0 next cycle. `rsp_sum`, `rsp_cout` and `rsp_id` hold their last values.
- Drain and grant in the same cycle: the new result replaces the old one, and `rsp_valid` stays 1. Back-to-back throughput is 1 result per cycle.
- Idle cycles (no `req_valid`): `rr_ptr` is unchanged.
- A requester must hold `req_valid` and its operands stable until granted. The arbiter does not check this.
- Arithmetic is modulo 2^24; the carry/borrow appears only on `rsp_cout`.

## Timing
- Reset values: `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `rr_ptr`=0. `req_ready`=0 while `rst`=1.
- Reset mid-operation discards any held result. Requests presented during reset are not accepted.
- Latency: a request granted in cycle t gives `rsp_valid`=1 with its result in cycle t+1.
- Combinational path per cycle: arbitration → operand mux → `padder24` → result register.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, all outputs hold and `req_ready`=0.
- Fairness: a continuously asserted requester is granted within NREQ grants.

## Structure
- Shared package `fpu_pkg`:
  - `FPU_MANT_W` = 24.
  - Function `clog2_min1` (returns at least 1, for IDW when NREQ is small).
- Sub-modules:
  - Exactly one instance of `padder24` as the shared datapath.
  - The round-robin selector is a natural separate sub-module, `rr_arb`.
    - Inputs: `req` vector, `ptr`.
    - Outputs: one-hot `gnt`, encoded `gnt_id`.
    - Purely combinational.
- State: result register and `rr_ptr` only.

## Test plan
- Reset, then one add: requester 0, A=0x000001, B=0x000002, cin=1, `rsp_ready`=1. Expect `req_ready`=0001 in that cycle; next cycle `rsp_valid`=1, `rsp_sum`=0x000004, `rsp_cout`=0, `rsp_id`=0.
- Subtract with borrow on requester 2: A=0x000005, B=0x000007, sub=1. Expect `rsp_sum`=0xFFFFFE, `rsp_cout`=0. Repeat with A=0x000007, B=0x000005: expect 0x000002, `rsp_cout`=1.
- Overflow: A=0xFFFFFF, B=0x000001, cin=0. Expect `rsp_sum`=0x000000, `rsp_cout`=1.
- Round-robin: all 4 requesters valid continuously, `rsp_ready`=1. Grants follow 0,1,2,3,0,…; `rsp_id` follows the same order on consecutive cycles with no bubbles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with requests pending. Expect `req_ready`=0 and all `rsp_*` stable. Release: drain and a new grant occur in the same cycle.
- Reset asserted while `rsp_valid`=1 and `rr_ptr`=2. Next cycle expect `rsp_valid`=0; the first grant after reset goes to the lowest valid requester starting from 0.
